// File: rtl/input_checker.sv
// input_checker: checks the player's button presses against the colour
// sequence shown by colourflash and reports round pass/fail to the game FSM.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for start with a nonzero round length
// WAIT_PRESS   | waiting for the next press; per-press timer running
// WAIT_RELEASE | correct press taken; waiting for all buttons released
// PASS         | round_pass high for one cycle, then back to IDLE
// FAIL         | round_fail high for one cycle, then back to IDLE

module input_checker #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] round_len,
    input  logic [2:0] segment [0:31],
    input  logic [3:0] player_input,
    output logic       busy,
    output logic [5:0] progress,
    output logic [3:0] expected,
    output logic       round_pass,
    output logic       round_fail
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_PRESS   = 3'd1,
        WAIT_RELEASE = 3'd2,
        PASS         = 3'd3,
        FAIL         = 3'd4
    } state_t;

    state_t             state;
    logic [3:0]         in_q;
    logic [3:0]         in_prev;
    logic [TIMER_W-1:0] timer;
    logic [5:0]         len;

    logic       press_event;
    logic       press_ok;
    logic [4:0] seg_idx;
    logic [1:0] seg_sel;
    logic [5:0] len_clamped;
    logic       unused_seg_bit2;

    // Press detection, the answer check and the clamped round length.
    always_comb begin
        press_event = (in_prev == 4'b0000) && (in_q != 4'b0000);
        press_ok    = $onehot(in_q) && (in_q == expected);
        len_clamped = (round_len > 6'd32) ? 6'd32 : round_len;
    end

    // Decode the expected button from the sequence entry at the current
    // position; the index saturates at 31 since progress can reach 32
    // while waiting for the final release.
    always_comb begin
        seg_idx         = (progress > 6'd31) ? 5'd31 : progress[4:0];
        seg_sel         = segment[seg_idx][1:0];
        expected        = 4'b0000;
        unused_seg_bit2 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            unused_seg_bit2 = unused_seg_bit2 ^ segment[k][2];
        end
        if (busy) begin
            expected = 4'b0001 << seg_sel;
        end
    end

    // Input pipeline, round FSM, timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_q       <= 4'b0000;
            in_prev    <= 4'b0000;
            timer      <= '0;
            len        <= 6'd0;
            progress   <= 6'd0;
            busy       <= 1'b0;
            round_pass <= 1'b0;
            round_fail <= 1'b0;
        end else begin
            in_q       <= player_input;
            in_prev    <= in_q;
            round_pass <= 1'b0;
            round_fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (round_len != 6'd0)) begin
                        len      <= len_clamped;
                        progress <= 6'd0;
                        timer    <= '0;
                        busy     <= 1'b1;
                        state    <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    timer <= timer + 1'b1;
                    // A press in the same cycle as the timeout wins.
                    if (press_event) begin
                        if (press_ok) begin
                            progress <= progress + 6'd1;
                            state    <= WAIT_RELEASE;
                        end else begin
                            round_fail <= 1'b1;
                            state      <= FAIL;
                        end
                    end else if (timer == TIMER_LAST) begin
                        round_fail <= 1'b1;
                        state      <= FAIL;
                    end
                end
                WAIT_RELEASE: begin
                    if (in_q == 4'b0000) begin
                        if (progress == len) begin
                            round_pass <= 1'b1;
                            state      <= PASS;
                        end else begin
                            timer <= '0;
                            state <= WAIT_PRESS;
                        end
                    end
                end
                PASS, FAIL: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_checker.sv
module tb_input_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] round_len;
    logic [2:0] segment [0:31];
    logic [3:0] player_input;
    logic       busy;
    logic [5:0] progress;
    logic [3:0] expected;
    logic       round_pass;
    logic       round_fail;

    int checks = 0;
    int errors = 0;
    int pass_total = 0;
    int fail_total = 0;
    int both_total = 0;

    input_checker #(.TIMEOUT(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .round_len    (round_len),
        .segment      (segment),
        .player_input (player_input),
        .busy         (busy),
        .progress     (progress),
        .expected     (expected),
        .round_pass   (round_pass),
        .round_fail   (round_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (round_pass) pass_total++;
        if (round_fail) fail_total++;
        if (round_pass && round_fail) both_total++;
    end

    typedef struct {
        logic [5:0]  rlen;
        int          npress;
        logic [15:0] presses;
        int          exp_pass;
        int          exp_fail;
        logic [5:0]  exp_prog;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_start(input logic [5:0] len);
        round_len = len;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] pat, input int hold, input int gap);
        player_input = pat;
        repeat (hold) step();
        player_input = 4'b0000;
        repeat (gap) step();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        int p0, f0, n;

        for (int k = 0; k < 32; k++) begin
            segment[k] = {((k % 3) == 0) ? 1'b1 : 1'b0, 2'(k % 4)};
        end
        reset = 1'b1;
        start = 1'b0;
        round_len = 6'd0;
        player_input = 4'b0000;

        vecs[0] = '{6'd3, 3, 16'h0421, 1, 0, 6'd3};
        vecs[1] = '{6'd4, 2, 16'h0081, 0, 1, 6'd1};
        vecs[2] = '{6'd2, 1, 16'h0003, 0, 1, 6'd0};
        vecs[3] = '{6'd4, 4, 16'h8421, 1, 0, 6'd4};
        vecs[4] = '{6'd2, 1, 16'h0002, 0, 1, 6'd0};
        vecs[5] = '{6'd2, 2, 16'h0061, 0, 1, 6'd1};

        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_progress", progress, 0);
        chk("rst_expected", expected, 0);
        chk("rst_pass", round_pass, 0);
        chk("rst_fail", round_fail, 0);
        reset = 1'b0;
        step();

        // Table-driven rounds.
        for (int v = 0; v < 6; v++) begin
            p0 = pass_total;
            f0 = fail_total;
            do_start(vecs[v].rlen);
            for (int i = 0; i < vecs[v].npress; i++) begin
                press(vecs[v].presses[i*4 +: 4], 4, 4);
            end
            wait_idle($sformatf("vec%0d_idle", v));
            chk($sformatf("vec%0d_pass", v), pass_total - p0, vecs[v].exp_pass);
            chk($sformatf("vec%0d_fail", v), fail_total - f0, vecs[v].exp_fail);
            chk($sformatf("vec%0d_progress", v), progress, vecs[v].exp_prog);
            repeat (2) step();
        end

        // Exact latency of busy, progress and round_pass.
        p0 = pass_total;
        do_start(6'd2);
        chk("lat_busy", busy, 1);
        chk("lat_exp0", expected, 4'b0001);
        player_input = 4'b0001;
        step();
        chk("lat_prog_early", progress, 0);
        step();
        chk("lat_prog", progress, 1);
        chk("lat_exp1", expected, 4'b0010);
        player_input = 4'b0000;
        repeat (2) step();
        player_input = 4'b0010;
        repeat (2) step();
        chk("lat_prog2", progress, 2);
        player_input = 4'b0000;
        step();
        chk("lat_pass_early", round_pass, 0);
        step();
        chk("lat_pass", round_pass, 1);
        chk("lat_busy_at_pulse", busy, 1);
        step();
        chk("lat_pass_done", round_pass, 0);
        chk("lat_busy_drop", busy, 0);
        chk("lat_prog_hold", progress, 2);
        chk("lat_exp_idle", expected, 0);
        chk("lat_pass_cnt", pass_total - p0, 1);

        // Timeout: fail exactly 20 cycles after WAIT_PRESS is entered.
        repeat (2) step();
        do_start(6'd2);
        n = 0;
        while (!round_fail && n < 100) begin
            step();
            n++;
        end
        chk("timeout_cycles", n, 20);
        step();
        chk("timeout_idle", busy, 0);

        // A held button never times out.
        repeat (2) step();
        f0 = fail_total;
        do_start(6'd2);
        player_input = 4'b0001;
        repeat (60) step();
        chk("held_nofail", fail_total - f0, 0);
        chk("held_busy", busy, 1);
        chk("held_prog", progress, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        player_input = 4'b0000;
        chk("held_rst_busy", busy, 0);
        chk("held_rst_prog", progress, 0);
        repeat (3) step();

        // Button held through start must be released before it counts.
        p0 = pass_total;
        f0 = fail_total;
        player_input = 4'b0001;
        repeat (3) step();
        do_start(6'd1);
        repeat (5) step();
        chk("hts_prog", progress, 0);
        chk("hts_busy", busy, 1);
        player_input = 4'b0000;
        repeat (3) step();
        press(4'b0001, 4, 4);
        wait_idle("hts_idle");
        chk("hts_pass", pass_total - p0, 1);
        chk("hts_fail", fail_total - f0, 0);

        // Zero length start is ignored.
        do_start(6'd0);
        repeat (2) step();
        chk("len0_busy", busy, 0);

        // Oversized length clamps to 32.
        p0 = pass_total;
        f0 = fail_total;
        do_start(6'd40);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("len40_exp%0d", k), expected, 4'b0001 << (k % 4));
            if (k == 31) begin
                chk("len40_prog31", progress, 31);
                chk("len40_busy31", busy, 1);
                chk("len40_nopass31", pass_total - p0, 0);
            end
            press(4'b0001 << (k % 4), 3, 3);
        end
        wait_idle("len40_idle");
        chk("len40_pass", pass_total - p0, 1);
        chk("len40_fail", fail_total - f0, 0);
        chk("len40_prog", progress, 32);

        // Reset mid-round at progress 2.
        p0 = pass_total;
        f0 = fail_total;
        do_start(6'd4);
        press(4'b0001, 3, 3);
        press(4'b0010, 3, 3);
        chk("mid_prog2", progress, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_prog", progress, 0);
        chk("mid_exp", expected, 0);
        chk("mid_pass_lvl", round_pass, 0);
        chk("mid_fail_lvl", round_fail, 0);
        repeat (25) step();
        chk("mid_no_pass", pass_total - p0, 0);
        chk("mid_no_fail", fail_total - f0, 0);

        // Second start while busy is ignored.
        p0 = pass_total;
        do_start(6'd4);
        press(4'b0001, 3, 3);
        do_start(6'd2);
        chk("restart_prog", progress, 1);
        press(4'b0010, 3, 3);
        chk("restart_nopass", pass_total - p0, 0);
        chk("restart_busy", busy, 1);
        press(4'b0100, 3, 3);
        press(4'b1000, 3, 3);
        wait_idle("restart_idle");
        chk("restart_pass", pass_total - p0, 1);
        chk("restart_prog4", progress, 4);

        // Segment changed mid-round is used at evaluation time.
        p0 = pass_total;
        do_start(6'd1);
        step();
        segment[0] = 3'b010;
        #1;
        chk("seg_exp", expected, 4'b0100);
        press(4'b0100, 3, 3);
        wait_idle("seg_idle");
        chk("seg_pass", pass_total - p0, 1);
        segment[0] = 3'b100;

        chk("mutex", both_total, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
